// File: rtl/program_loader.sv
// Boot loader write side: turns framed bytes (SYNC, addr, len, payload, checksum)
// into byte writes and holds the CPU while a frame is in flight.
//   state  | meaning
//   IDLE   | hunting for SYNC_BYTE, other bytes dropped
//   ADDR   | next byte is the start address
//   LEN    | next byte is the payload length (0 = 256)
//   DATA   | each byte becomes one memory write
//   CHK    | next byte is the checksum
//   DONE   | one-cycle done pulse, CPU released
//   ERR    | one-cycle error pulse (bad checksum or timeout), CPU released
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_write,
  output logic       cpu_hold,
  output logic       done,
  output logic       error
);

  // Down-counter holds the idle cycles still tolerated; zero with no accept means expiry.
  localparam int unsigned       TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             in_ready_q, in_ready_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             mem_write_q, mem_write_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             accept;
  logic             in_frame;
  logic             go_done;
  logic             go_err;
  logic [7:0]       chk_sum;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    tmr_d       = tmr_q;
    in_ready_d  = in_ready_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    cpu_hold_d  = cpu_hold_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    go_done     = 1'b0;
    go_err      = 1'b0;

    accept   = in_valid && in_ready_q;
    in_frame = (state_q == S_ADDR) || (state_q == S_LEN) ||
               (state_q == S_DATA) || (state_q == S_CHK);
    chk_sum  = sum_q + in_data;

    if (in_frame) begin
      if (accept) begin
        tmr_d = TMR_LOAD;
      end else if (tmr_q == '0) begin
        go_err = 1'b1;
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        tmr_d      = '0;
        if (accept && in_data == SYNC_BYTE) begin
          state_d    = S_ADDR;
          cpu_hold_d = 1'b1;
          sum_d      = 8'h00;
          tmr_d      = TMR_LOAD;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d  = in_data;
          sum_d   = in_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          remaining_d = in_data;
          sum_d       = chk_sum;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          mem_write_d = 1'b1;
          addr_d      = addr_q + 8'd1;
          sum_d       = chk_sum;
          remaining_d = remaining_q - 8'd1;
          // remaining of 0 decrements to 255, so a length byte of 0 yields 256 writes
          if (remaining_q == 8'd1) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (chk_sum == 8'h00) begin
            go_done = 1'b1;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
        tmr_d      = '0;
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
        cpu_hold_d = 1'b0;
        tmr_d      = '0;
      end
    endcase

    if (go_done) begin
      state_d    = S_DONE;
      in_ready_d = 1'b0;
      cpu_hold_d = 1'b0;
      done_d     = 1'b1;
      tmr_d      = '0;
    end else if (go_err) begin
      state_d    = S_ERR;
      in_ready_d = 1'b0;
      cpu_hold_d = 1'b0;
      error_d    = 1'b1;
      tmr_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 8'h00;
      remaining_q <= 8'h00;
      sum_q       <= 8'h00;
      tmr_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      mem_write_q <= 1'b0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      tmr_q       <= tmr_d;
      in_ready_q  <= in_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: per-cycle vector table for framing, writes
// and reset, plus hand-written timeout sequences.
module tb_program_loader;

  localparam int unsigned TIMEOUT = 1023;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_write;
  logic       cpu_hold;
  logic       done;
  logic       error;

  program_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_rdy;
    logic       e_wr;
    logic [7:0] e_addr;
    logic [7:0] e_wd;
    logic       e_hold;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic rdy, input logic wr, input logic [7:0] a,
                     input logic [7:0] wd, input logic hold, input logic dn,
                     input logic er);
    vec_t t;
    t.r = r; t.v = v; t.d = d;
    t.e_rdy = rdy; t.e_wr = wr; t.e_addr = a; t.e_wd = wd;
    t.e_hold = hold; t.e_done = dn; t.e_err = er;
    vq.push_back(t);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_run(input string name, input int n);
    logic early;
    early = 1'b0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 8'h00);
      if (error !== 1'b0 || done !== 1'b0 || mem_write !== 1'b0 ||
          cpu_hold !== 1'b1 || in_ready !== 1'b1) early = 1'b1;
    end
    chk1(name, early, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    //   r  v  data   rdy wr addr   wdata  hold dn er
    // reset, then frame 10: 11 22 33 with good checksum 87
    add(1, 0, 8'h00,  0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(1, 0, 8'h00,  0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 8'hA5,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h10,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h03,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h11,  1, 1, 8'h10, 8'h11, 1, 0, 0);
    add(0, 1, 8'h22,  1, 1, 8'h11, 8'h22, 1, 0, 0);
    add(0, 1, 8'h33,  1, 1, 8'h12, 8'h33, 1, 0, 0);
    add(0, 1, 8'h87,  0, 0, 8'h00, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    // same frame, bad checksum 88; SYNC offered during ERR must not be taken
    add(0, 1, 8'hA5,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h10,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h03,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h11,  1, 1, 8'h10, 8'h11, 1, 0, 0);
    add(0, 1, 8'h22,  1, 1, 8'h11, 8'h22, 1, 0, 0);
    add(0, 1, 8'h33,  1, 1, 8'h12, 8'h33, 1, 0, 0);
    add(0, 1, 8'h88,  0, 0, 8'h00, 8'h00, 0, 0, 1);
    add(0, 1, 8'hA5,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    // address wrap FE,FF,00 with valid gaps; checksum F9
    add(0, 1, 8'hA5,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'hFE,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 0, 8'h77,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h03,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h01,  1, 1, 8'hFE, 8'h01, 1, 0, 0);
    add(0, 0, 8'h99,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h02,  1, 1, 8'hFF, 8'h02, 1, 0, 0);
    add(0, 1, 8'h03,  1, 1, 8'h00, 8'h03, 1, 0, 0);
    add(0, 1, 8'hF9,  0, 0, 8'h00, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    // junk before SYNC, then reset in the middle of DATA
    add(0, 1, 8'h00,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 8'hFF,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 8'h5A,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 8'hA5,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h40,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h02,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h55,  1, 1, 8'h40, 8'h55, 1, 0, 0);
    add(1, 1, 8'h66,  0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(0, 0, 8'h00,  1, 0, 8'h00, 8'h00, 0, 0, 0);
    // fresh frame after reset; SYNC value in payload is plain data; checksum 2A
    add(0, 1, 8'hA5,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h30,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'h01,  1, 0, 8'h00, 8'h00, 1, 0, 0);
    add(0, 1, 8'hA5,  1, 1, 8'h30, 8'hA5, 1, 0, 0);
    add(0, 1, 8'h2A,  0, 0, 8'h00, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00,  1, 0, 8'h00, 8'h00, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].v, vq[i].d);
      chk1($sformatf("v%0d_in_ready", i),  in_ready,  vq[i].e_rdy);
      chk1($sformatf("v%0d_mem_write", i), mem_write, vq[i].e_wr);
      chk1($sformatf("v%0d_cpu_hold", i),  cpu_hold,  vq[i].e_hold);
      chk1($sformatf("v%0d_done", i),      done,      vq[i].e_done);
      chk1($sformatf("v%0d_error", i),     error,     vq[i].e_err);
      if (vq[i].e_wr || vq[i].r) begin
        chk8($sformatf("v%0d_mem_addr", i),  mem_addr,  vq[i].e_addr);
        chk8($sformatf("v%0d_mem_wdata", i), mem_wdata, vq[i].e_wd);
      end
    end

    // timeout in DATA after one of two payload bytes
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h20);
    step(1'b0, 1'b1, 8'h02);
    step(1'b0, 1'b1, 8'h07);
    chk1("t5_write", mem_write, 1'b1);
    chk8("t5_addr", mem_addr, 8'h20);
    chk8("t5_wdata", mem_wdata, 8'h07);
    idle_run("t5_no_early_timeout", TIMEOUT - 1);
    step(1'b0, 1'b0, 8'h00);
    chk1("t5_error", error, 1'b1);
    chk1("t5_no_done", done, 1'b0);
    chk1("t5_hold_low", cpu_hold, 1'b0);
    chk1("t5_ready_low", in_ready, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk1("t5_error_pulse", error, 1'b0);
    chk1("t5_idle_ready", in_ready, 1'b1);

    // an accept at the last tolerated cycle restarts the timeout window
    step(1'b0, 1'b1, 8'hA5);
    idle_run("tr_window1", TIMEOUT - 1);
    step(1'b0, 1'b1, 8'h50);
    chk1("tr_accept_no_error", error, 1'b0);
    chk1("tr_accept_hold", cpu_hold, 1'b1);
    idle_run("tr_window2", TIMEOUT - 1);
    step(1'b0, 1'b0, 8'h00);
    chk1("tr_error", error, 1'b1);
    chk1("tr_hold_low", cpu_hold, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk1("tr_idle_ready", in_ready, 1'b1);
    chk1("tr_idle_error", error, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
